periph_bus_master: RTL

- CPU-side initiator for the bank of single-bit memory-mapped I/O peripherals; it generates the strobes those peripherals respond to.
- Accepts one request at a time: read input bit, write output bit, or set direction.
- Decodes the address to a one-hot strobe and drives or samples the shared 1-bit data bus with correct setup and turnaround.
- Returns read data and an ack pulse. Sits between the core's load/store unit and the peripheral array.

---
 rtl/periph_bus_master_pkg.sv | 20 ++
 rtl/periph_addr_decode.sv | 20 ++
 rtl/periph_bus_master.sv | 114 +++++++++++
 3 files changed

// File: rtl/periph_bus_master_pkg.sv
// Shared encodings for the single-bit peripheral bus master and its address decoder.
package periph_bus_master_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SETDIR = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam logic BUS_IDLE = 1'bz;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational address to one-hot peripheral select, with an out-of-range flag.
module periph_addr_decode #(
    parameter int NPERIPH = 8,
    parameter int AW      = 3
) (
    input  logic [AW-1:0]      addr,
    input  logic               en,
    output logic [NPERIPH-1:0] onehot,
    output logic               oor
);

    always_comb begin
        oor    = (int'(addr) >= NPERIPH);
        onehot = '0;
        for (int i = 0; i < NPERIPH; i++) begin
            if (en && !oor && (int'(addr) == i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/periph_bus_master.sv
// One-request-at-a-time initiator: SETUP -> STROBE -> DONE sequence on the shared 1-bit bus.
module periph_bus_master
    import periph_bus_master_pkg::*;
#(
    parameter int NPERIPH = 8,
    parameter int AW      = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req,
    input  logic [1:0]         op,
    input  logic [AW-1:0]      addr,
    input  logic               wdata,
    output logic               busy,
    output logic               ack,
    output logic               err,
    output logic               rdata,
    inout  wire                data_bus,
    output logic [NPERIPH-1:0] mem_read,
    output logic [NPERIPH-1:0] mem_write,
    output logic [NPERIPH-1:0] load_dir
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            rdata_q, rdata_d;

    logic [AW-1:0]      dec_addr;
    logic               dec_en;
    logic [NPERIPH-1:0] dec_onehot;
    logic               dec_oor;
    logic               drive_en;

    // The one decoder range-checks the live address in IDLE and selects the latched one later.
    assign dec_addr = (state_q == ST_IDLE) ? addr : addr_q;
    assign dec_en   = (state_q == ST_STROBE);

    periph_addr_decode #(
        .NPERIPH (NPERIPH),
        .AW      (AW)
    ) u_dec (
        .addr    (dec_addr),
        .en      (dec_en),
        .onehot  (dec_onehot),
        .oor     (dec_oor)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = op_e'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (dec_oor || (op == OP_RSVD)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                if (op_q == OP_READ) rdata_d = data_bus;
                state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Error transactions never reach SETUP/STROBE, so they never drive or strobe.
    assign drive_en = ((state_q == ST_SETUP) || (state_q == ST_STROBE)) && (op_q != OP_READ);
    assign data_bus = drive_en ? wdata_q : BUS_IDLE;

    assign mem_read  = (op_q == OP_READ)   ? dec_onehot : '0;
    assign mem_write = (op_q == OP_WRITE)  ? dec_onehot : '0;
    assign load_dir  = (op_q == OP_SETDIR) ? dec_onehot : '0;

    assign busy  = (state_q != ST_IDLE);
    assign ack   = (state_q == ST_DONE);
    assign err   = ack && err_q;
    assign rdata = rdata_q;

endmodule
